// File: rtl/mips_cpu_regalu_core.sv
// -----------------------------------------------------------------------------
// mips_cpu_regalu_core
//   Datapath core of the multicycle MIPS32 bus CPU: a 32x32 general register
//   file (r0 hardwired to zero) plus a purely combinational integer ALU.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   wr_en/addr/data   register write port (writes to r0 are discarded)
//   rd_addr_a/b       asynchronous read ports -> rd_data_a/b (no write bypass)
//   register_v0       continuous copy of r2 ($v0), for debug
//   alu_op/a/b/sa     ALU opcode, operands, immediate shift amount
//   alu_result/zero   ALU result and (result == 0) flag
//
// Build option
//   MIPS_REGALU_SLTU_EN  adds op 12 SLTU and op 13 NOR. Without it those
//                        opcodes return 0 like every other unused opcode.
// -----------------------------------------------------------------------------
module mips_cpu_regalu_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr_a,
    output logic [31:0] rd_data_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_b,
    output logic [31:0] register_v0,
    input  logic [4:0]  alu_op,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [4:0]  alu_sa,
    output logic [31:0] alu_result,
    output logic        alu_zero
);

    typedef enum logic [4:0] {
        OP_AND  = 5'd0,
        OP_OR   = 5'd1,
        OP_ADD  = 5'd2,
        OP_SUB  = 5'd3,
        OP_SLT  = 5'd4,
        OP_XOR  = 5'd5,
        OP_SLL  = 5'd6,
        OP_SRL  = 5'd7,
        OP_SRA  = 5'd8,
        OP_SLLV = 5'd9,
        OP_SRLV = 5'd10,
        OP_SRAV = 5'd11,
        OP_SLTU = 5'd12,
        OP_NOR  = 5'd13
    } alu_op_e;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] regs [32];

    // Entry 0 is cleared by reset and never written; the read muxes also
    // force it to zero so r0 is defined even before the first reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a   = (rd_addr_a == 5'd0) ? 32'h0 : regs[rd_addr_a];
    assign rd_data_b   = (rd_addr_b == 5'd0) ? 32'h0 : regs[rd_addr_b];
    assign register_v0 = regs[2];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [4:0] var_sa;
    assign var_sa = alu_a[4:0];   // variable shifts ignore a[31:5]

    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_SLT:  alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_SLL:  alu_result = alu_b << alu_sa;
            OP_SRL:  alu_result = alu_b >> alu_sa;
            OP_SRA:  alu_result = $unsigned($signed(alu_b) >>> alu_sa);
            OP_SLLV: alu_result = alu_b << var_sa;
            OP_SRLV: alu_result = alu_b >> var_sa;
            OP_SRAV: alu_result = $unsigned($signed(alu_b) >>> var_sa);
`ifdef MIPS_REGALU_SLTU_EN
            OP_SLTU: alu_result = {31'h0, alu_a < alu_b};
            OP_NOR:  alu_result = ~(alu_a | alu_b);
`endif
            default: alu_result = 32'h0;
        endcase
    end

    assign alu_zero = (alu_result == 32'h0);

endmodule

// File: tb/tb_mips_cpu_regalu_core.sv
module tb_mips_cpu_regalu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b, register_v0;
    logic [4:0]  alu_op, alu_sa;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;

    int checks   = 0;
    int failures = 0;

    mips_cpu_regalu_core dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .register_v0(register_v0),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_sa(alu_sa),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sa;
        logic [31:0] exp_res;
        logic        exp_zero;
    } alu_vec_t;

    localparam int NV = 20;
    alu_vec_t vecs [NV];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Drive a write between edges, let one rising edge commit it.
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    initial begin
        // op, a, b, sa, expected result, expected zero
        vecs[0]  = '{"and",      5'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd3,  32'h00F000F0, 1'b0};
        vecs[1]  = '{"or",       5'd1,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd3,  32'hFFF0FFF0, 1'b0};
        vecs[2]  = '{"xor",      5'd5,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd3,  32'hFF00FF00, 1'b0};
        vecs[3]  = '{"add_wrap", 5'd2,  32'hFFFFFFFF, 32'h00000001, 5'd7,  32'h00000000, 1'b1};
        vecs[4]  = '{"add",      5'd2,  32'h00000007, 32'h00000008, 5'd1,  32'h0000000F, 1'b0};
        vecs[5]  = '{"sub",      5'd3,  32'h00000005, 32'h00000007, 5'd2,  32'hFFFFFFFE, 1'b0};
        vecs[6]  = '{"slt_neg",  5'd4,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0};
        vecs[7]  = '{"slt_pos",  5'd4,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b1};
        vecs[8]  = '{"sll31",    5'd6,  32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0};
        vecs[9]  = '{"sra4",     5'd8,  32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0};
        vecs[10] = '{"sra_pos",  5'd8,  32'h00000000, 32'h40000000, 5'd4,  32'h04000000, 1'b0};
        vecs[11] = '{"srl4",     5'd7,  32'h00000000, 32'h80000000, 5'd4,  32'h08000000, 1'b0};
        vecs[12] = '{"srlv",     5'd10, 32'h00000024, 32'h80000000, 5'd0,  32'h08000000, 1'b0};
        vecs[13] = '{"sllv",     5'd9,  32'hFFFFFFE3, 32'h00000001, 5'd9,  32'h00000008, 1'b0};
        vecs[14] = '{"srav",     5'd11, 32'h00000021, 32'h80000000, 5'd7,  32'hC0000000, 1'b0};
        vecs[15] = '{"op31",     5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000, 1'b1};
        vecs[16] = '{"op14",     5'd14, 32'h12345678, 32'h00000001, 5'd1,  32'h00000000, 1'b1};
`ifdef MIPS_REGALU_SLTU_EN
        vecs[17] = '{"sltu_lt",  5'd12, 32'h00000001, 32'h00000002, 5'd0,  32'h00000001, 1'b0};
        vecs[18] = '{"sltu_big", 5'd12, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1};
        vecs[19] = '{"nor",      5'd13, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0};
`else
        vecs[17] = '{"op12",     5'd12, 32'h00000001, 32'h00000002, 5'd0,  32'h00000000, 1'b1};
        vecs[18] = '{"op12_b",   5'd12, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1};
        vecs[19] = '{"op13",     5'd13, 32'h00000000, 32'h00000000, 5'd0,  32'h00000000, 1'b1};
`endif

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = 5'd5; rd_addr_b = 5'd2;
        alu_op = '0; alu_a = '0; alu_b = '0; alu_sa = '0;

        // ---- ALU table ----
        for (int i = 0; i < NV; i++) begin
            alu_op = vecs[i].op; alu_a = vecs[i].a; alu_b = vecs[i].b; alu_sa = vecs[i].sa;
            #1;
            check32({"alu_", vecs[i].name}, alu_result, vecs[i].exp_res);
            check1({"zero_", vecs[i].name}, alu_zero, vecs[i].exp_zero);
        end

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check32("rst_r5", rd_data_a, 32'h0);
        check32("rst_v0", register_v0, 32'h0);
        @(negedge clk); rst = 1'b0;

        // ---- write r5, then reset with a write pending (reset wins) ----
        write_reg(5'd5, 32'hDEADBEEF);
        check32("r5_written", rd_data_a, 32'hDEADBEEF);
        write_reg(5'd2, 32'h11111111);
        check32("v0_pre_rst", register_v0, 32'h11111111);
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        check32("rst_clears_r5", rd_data_a, 32'h0);
        check32("rst_clears_v0", register_v0, 32'h0);

        // ---- r0 hardwired ----
        write_reg(5'd0, 32'h12345678);
        rd_addr_a = 5'd0; rd_addr_b = 5'd0; #1;
        check32("r0_a", rd_data_a, 32'h0);
        check32("r0_b", rd_data_b, 32'h0);

        // ---- r2 / v0, both ports on same index ----
        write_reg(5'd2, 32'h0000ABCD);
        check32("v0_abcd", register_v0, 32'h0000ABCD);
        rd_addr_a = 5'd2; rd_addr_b = 5'd2; #1;
        check32("r2_a", rd_data_a, 32'h0000ABCD);
        check32("r2_b", rd_data_b, 32'h0000ABCD);

        // ---- wr_en=0 leaves state alone ----
        @(negedge clk);
        wr_en = 1'b0; wr_addr = 5'd2; wr_data = 32'h55555555;
        @(posedge clk); #1;
        check32("no_wr_v0", register_v0, 32'h0000ABCD);

        // ---- read-during-write: old value until the edge ----
        write_reg(5'd3, 32'h00000001);
        @(negedge clk);
        rd_addr_a = 5'd3; rd_addr_b = 5'd31;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000007;
        #1;
        check32("rdw_before", rd_data_a, 32'h00000001);
        @(posedge clk); #1;
        wr_en = 1'b0;
        check32("rdw_after", rd_data_a, 32'h00000007);

        // ---- high index, independent ports ----
        write_reg(5'd31, 32'hA5A5A5A5);
        check32("r31_b", rd_data_b, 32'hA5A5A5A5);
        check32("r3_a_kept", rd_data_a, 32'h00000007);
        check32("v0_kept", register_v0, 32'h0000ABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
